// File: rtl/input_conditioner.sv
// input_conditioner: per-channel sync, debounce, edge pulses, press counters.
// Optional long-press detection is enabled by defining INPUT_COND_LONGPRESS_EN.
module input_conditioner #(
    parameter int CHANNELS         = 4,
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 270000,
    parameter int LONGPRESS_CYCLES = 27000000,
    parameter int CNT_W            = 8,
    parameter logic [CHANNELS-1:0] INVERT    = '0,
    parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
    input  logic                      clk27,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       din,
    input  logic [CHANNELS-1:0]       cnt_clr,
    output logic [CHANNELS-1:0]       dout,
    output logic [CHANNELS-1:0]       rise,
    output logic [CHANNELS-1:0]       fall,
    output logic [CHANNELS-1:0]       long_press,
    output logic [CHANNELS*CNT_W-1:0] press_cnt
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic [DEB_W-1:0]       deb_q;
            logic [CNT_W-1:0]       cnt_q;
            logic                   dout_q;
            logic                   rise_q;
            logic                   fall_q;
            logic                   s;
            logic                   accept;

            assign s      = sync_q[SYNC_STAGES-1];
            assign accept = (s != dout_q) && (deb_q == DEB_LAST);

            assign dout[i] = dout_q;
            assign rise[i] = rise_q;
            assign fall[i] = fall_q;
            assign press_cnt[i*CNT_W +: CNT_W] = cnt_q;

            // Inversion-corrected pin level through the synchronizer chain
            always_ff @(posedge clk27 or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= {SYNC_STAGES{RESET_VAL[i]}};
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], din[i] ^ INVERT[i]};
                end
            end

            // Accept a new level only after it has held for the full window
            always_ff @(posedge clk27 or negedge reset_n) begin
                if (!reset_n) begin
                    deb_q  <= '0;
                    dout_q <= RESET_VAL[i];
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    rise_q <= accept && s;
                    fall_q <= accept && !s;
                    if (s == dout_q || accept) begin
                        deb_q <= '0;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                    if (accept) begin
                        dout_q <= s;
                    end
                end
            end

            // Wrapping press counter; a clear coincident with a rise counts it
            always_ff @(posedge clk27 or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else if (cnt_clr[i]) begin
                    cnt_q <= CNT_W'(rise_q);
                end else begin
                    cnt_q <= cnt_q + CNT_W'(rise_q);
                end
            end

`ifdef INPUT_COND_LONGPRESS_EN
            localparam int HOLD_W = $clog2(LONGPRESS_CYCLES + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONGPRESS_CYCLES);
            localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONGPRESS_CYCLES - 1);

            logic [HOLD_W-1:0] hold_q;
            logic              lp_q;

            assign long_press[i] = lp_q;

            // Saturating hold timer; pulses once as it reaches the limit
            always_ff @(posedge clk27 or negedge reset_n) begin
                if (!reset_n) begin
                    hold_q <= '0;
                    lp_q   <= 1'b0;
                end else if (!dout_q) begin
                    hold_q <= '0;
                    lp_q   <= 1'b0;
                end else begin
                    lp_q <= (hold_q == HOLD_FIRE);
                    if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
            end
`else
            assign long_press[i] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus, window-based reference model,
// per-cycle comparison plus literal spot checks.
`timescale 1ns/1ps
module tb_input_conditioner;

    localparam int CH = 2;
    localparam int SS = 2;
    localparam int D  = 8;
    localparam int L  = 32;
    localparam int CW = 4;
    localparam logic [1:0] INV = 2'b10;
    localparam logic [1:0] RV  = 2'b00;
`ifdef INPUT_COND_LONGPRESS_EN
    localparam logic LP_EN = 1'b1;
`else
    localparam logic LP_EN = 1'b0;
`endif

    logic          clk27 = 1'b0;
    logic          reset_n;
    logic [1:0]    din;
    logic [1:0]    cnt_clr;
    logic [1:0]    dout;
    logic [1:0]    rise;
    logic [1:0]    fall;
    logic [1:0]    long_press;
    logic [7:0]    press_cnt;

    int total = 0;
    int bad   = 0;

    input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D),
        .LONGPRESS_CYCLES(L), .CNT_W(CW), .INVERT(INV), .RESET_VAL(RV)
    ) dut (
        .clk27(clk27), .reset_n(reset_n), .din(din), .cnt_clr(cnt_clr),
        .dout(dout), .rise(rise), .fall(fall), .long_press(long_press),
        .press_cnt(press_cnt)
    );

    always #5 clk27 = ~clk27;

    // Reference model: x history (bit 0 = most recent sample) and outputs
    logic [SS+D-2:0] xh [CH];
    logic [1:0]      m_dout, m_rise, m_fall, m_lp;
    logic [CW-1:0]   m_cnt [CH];
    int              rise_edge [CH];
    int              edge_n = 0;

    // Level at s over the last D decisions all differs from the old dout
    function automatic logic all_diff(logic [SS+D-2:0] h, logic old);
        logic r = 1'b1;
        for (int j = SS - 1; j <= SS + D - 2; j++) begin
            if (h[j] == old) r = 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) begin
                xh[c]        <= {(SS+D-1){RV[c]}};
                m_cnt[c]     <= '0;
                rise_edge[c] <= -100000;
            end
            m_dout <= RV;
            m_rise <= '0;
            m_fall <= '0;
            m_lp   <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (all_diff(xh[c], m_dout[c])) begin
                    m_dout[c] <= !m_dout[c];
                    m_rise[c] <= !m_dout[c];
                    m_fall[c] <= m_dout[c];
                    if (!m_dout[c]) rise_edge[c] <= edge_n;
                end else begin
                    m_rise[c] <= 1'b0;
                    m_fall[c] <= 1'b0;
                end
                m_lp[c] <= LP_EN && m_dout[c] && (edge_n - rise_edge[c] == L);
                m_cnt[c] <= cnt_clr[c] ? CW'(m_rise[c])
                                       : m_cnt[c] + CW'(m_rise[c]);
                xh[c] <= {xh[c][SS+D-3:0], din[c] ^ INV[c]};
            end
        end
        if (reset_n) edge_n <= edge_n + 1;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk27) begin
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("dout%0d", c), 32'(dout[c]), 32'(m_dout[c]));
            chk($sformatf("rise%0d", c), 32'(rise[c]), 32'(m_rise[c]));
            chk($sformatf("fall%0d", c), 32'(fall[c]), 32'(m_fall[c]));
            chk($sformatf("lp%0d", c), 32'(long_press[c]), 32'(m_lp[c]));
            chk($sformatf("cnt%0d", c), 32'(press_cnt[c*CW +: CW]),
                32'(m_cnt[c]));
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk27);
        #1;
    endtask

    task automatic press0();
        din[0] = 1'b1;
        tick(12);
        din[0] = 1'b0;
        tick(12);
    endtask

    initial begin
        reset_n = 1'b0;
        din     = 2'b11;
        cnt_clr = 2'b00;
        tick(3);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_pulses", 32'({rise, fall, long_press}), 32'h0);
        chk("rst_cnt", 32'(press_cnt), 32'h0);

        // Release with ch0 already high: 10-edge latency
        reset_n = 1'b1;
        tick(9);
        chk("rel_e9_dout0", 32'(dout[0]), 32'h0);
        tick(1);
        chk("rel_e10_dout0", 32'(dout[0]), 32'h1);
        chk("rel_e10_rise0", 32'(rise[0]), 32'h1);
        chk("rel_ch1_quiet", 32'({dout[1], rise[1]}), 32'h0);
        tick(1);
        chk("rel_rise0_off", 32'(rise[0]), 32'h0);
        chk("rel_cnt0", 32'(press_cnt[3:0]), 32'h1);

        // Inversion: ch1 active-low
        din[1] = 1'b0;
        tick(9);
        chk("inv_e9_dout1", 32'(dout[1]), 32'h0);
        tick(1);
        chk("inv_e10_dout1", 32'(dout[1]), 32'h1);
        chk("inv_e10_rise1", 32'(rise[1]), 32'h1);
        chk("inv_ch0_kept", 32'(dout[0]), 32'h1);
        tick(1);
        chk("inv_cnt1", 32'(press_cnt[7:4]), 32'h1);
        din[1] = 1'b1;
        tick(20);

        // Glitch: 7 cycles rejected
        din[0] = 1'b0;
        tick(15);
        din[0] = 1'b1;
        tick(7);
        din[0] = 1'b0;
        tick(20);
        chk("glitch_dout0", 32'(dout[0]), 32'h0);
        chk("glitch_cnt0", 32'(press_cnt[3:0]), 32'h1);

        // 8-cycle pulse accepted
        din[0] = 1'b1;
        tick(8);
        din[0] = 1'b0;
        tick(1);
        chk("p8_e9_rise0", 32'(rise[0]), 32'h0);
        tick(1);
        chk("p8_e10_rise0", 32'(rise[0]), 32'h1);
        tick(7);
        chk("p8_fall_early", 32'(fall[0]), 32'h0);
        tick(1);
        chk("p8_fall0", 32'(fall[0]), 32'h1);
        tick(10);
        chk("p8_cnt0", 32'(press_cnt[3:0]), 32'h2);

        // Long press: held 40 cycles after rise
        din[0] = 1'b1;
        tick(10);
        chk("lp_rise0", 32'(rise[0]), 32'h1);
        tick(31);
        chk("lp_early", 32'(long_press[0]), 32'h0);
        tick(1);
        chk("lp_fire", 32'(long_press[0]), 32'(LP_EN));
        tick(1);
        chk("lp_single", 32'(long_press[0]), 32'h0);
        tick(7);
        din[0] = 1'b0;
        tick(15);

        // Wrap and clear
        cnt_clr[0] = 1'b1;
        tick(1);
        cnt_clr[0] = 1'b0;
        chk("clr_cnt0", 32'(press_cnt[3:0]), 32'h0);
        for (int k = 0; k < 15; k++) press0();
        chk("wrap15", 32'(press_cnt[3:0]), 32'hf);
        press0();
        chk("wrap16", 32'(press_cnt[3:0]), 32'h0);
        din[0] = 1'b1;
        tick(10);
        chk("p17_rise0", 32'(rise[0]), 32'h1);
        cnt_clr[0] = 1'b1;
        tick(1);
        cnt_clr[0] = 1'b0;
        chk("clr_rise_cnt0", 32'(press_cnt[3:0]), 32'h1);
        din[0] = 1'b0;
        tick(15);

        // Reset during debounce
        din[0] = 1'b1;
        tick(7);
        reset_n = 1'b0;
        tick(2);
        chk("mid_rst_dout", 32'(dout), 32'h0);
        chk("mid_rst_pulse", 32'({rise, fall}), 32'h0);
        chk("mid_rst_cnt", 32'(press_cnt), 32'h0);
        reset_n = 1'b1;
        tick(9);
        chk("mid_e9_dout0", 32'(dout[0]), 32'h0);
        tick(1);
        chk("mid_e10_dout0", 32'(dout[0]), 32'h1);
        chk("mid_e10_rise0", 32'(rise[0]), 32'h1);
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
